// File: rtl/burst_stream_buffer.sv
// burst_stream_buffer: circular FIFO that regroups an irregular word stream into
// fixed-length output bursts with first/last markers, back-pressure and error words
module burst_stream_buffer #(
   parameter int              WDTH          = 32,
   parameter int              DEPTH         = 64,
   parameter int              LOG_DEPTH     = 6,
   parameter int              BURST_LEN     = 8,
   parameter int              LOG_BURST_LEN = 3,
   parameter logic [WDTH-1:0] ERR_CODE      = 32'hDEADBEEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WDTH-1:0]      in_data,
   input  logic                 in_nd,
   input  logic                 mode,
   input  logic                 flush,
   input  logic                 out_ready,
   output logic [WDTH-1:0]      out_data,
   output logic                 out_nd,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 out_err,
   output logic [LOG_DEPTH:0]   count,
   output logic                 overflow
);
   typedef enum logic {IDLE, BURST} state_t;
   localparam logic [LOG_DEPTH:0]     C_FULL = (LOG_DEPTH+1)'(DEPTH);
   localparam logic [LOG_DEPTH:0]     C_BLEN = (LOG_DEPTH+1)'(BURST_LEN);
   localparam logic [LOG_BURST_LEN:0] C_ONE  = (LOG_BURST_LEN+1)'(1);
   state_t                  r_state, w_next;
   logic [WDTH-1:0]         r_mem [DEPTH];
   logic [LOG_DEPTH-1:0]    r_wr_ptr, r_rd_ptr;
   logic [LOG_DEPTH:0]      r_count;
   logic [LOG_BURST_LEN:0]  r_len, r_idx, w_len, w_idx;
   logic [WDTH-1:0]         r_out_data;
   logic                    r_out_nd, r_out_first, r_out_last, r_out_err;
   logic                    r_overflow, r_err_pending, r_flush_pending;
   logic                    w_load_ok, w_push, w_drop, w_pop, w_load_err, w_first, w_last;
   assign w_load_ok = !r_out_nd || out_ready;
   assign w_push    = in_nd && (r_count != C_FULL);
   assign w_drop    = in_nd && (r_count == C_FULL);
   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_load_err = 1'b0;
      w_first    = 1'b0;
      w_last     = 1'b0;
      w_len      = r_len;
      w_idx      = r_idx;
      if (r_state == IDLE) begin
         if (r_err_pending) begin
            w_load_err = w_load_ok;
         end else if (!mode) begin
            w_pop   = w_load_ok && (r_count != '0);
            w_first = 1'b1;
            w_last  = 1'b1;
         end else if (r_count >= C_BLEN) begin
            w_next = BURST;
            w_len  = (LOG_BURST_LEN+1)'(BURST_LEN);
            w_idx  = '0;
         end else if (r_flush_pending && (r_count != '0)) begin
            w_next = BURST;
            w_len  = r_count[LOG_BURST_LEN:0];
            w_idx  = '0;
         end
      end else begin
         // the burst was sized against count, so the FIFO cannot run dry mid-burst
         w_pop   = w_load_ok;
         w_first = (r_idx == '0);
         w_last  = (r_idx == r_len - C_ONE);
         w_idx   = w_pop ? r_idx + C_ONE : r_idx;
         w_next  = (w_pop && w_last) ? IDLE : BURST;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         r_len           <= '0;
         r_idx           <= '0;
         r_out_data      <= '0;
         r_out_nd        <= 1'b0;
         r_out_first     <= 1'b0;
         r_out_last      <= 1'b0;
         r_out_err       <= 1'b0;
         r_overflow      <= 1'b0;
         r_err_pending   <= 1'b0;
         r_flush_pending <= 1'b0;
      end else begin
         r_state         <= w_next;
         r_len           <= w_len;
         r_idx           <= w_idx;
         r_wr_ptr        <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_rd_ptr        <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
         r_count         <= r_count + (LOG_DEPTH+1)'(w_push) - (LOG_DEPTH+1)'(w_pop);
         r_overflow      <= r_overflow || w_drop;
         r_err_pending   <= (r_err_pending && !w_load_err) || w_drop;
         r_flush_pending <= flush || (r_flush_pending && !(r_state == IDLE && r_count == '0 && !w_load_err));
         if (w_pop || w_load_err) begin
            r_out_nd    <= 1'b1;
            r_out_data  <= w_load_err ? ERR_CODE : r_mem[r_rd_ptr];
            r_out_first <= w_load_err || w_first;
            r_out_last  <= w_load_err || w_last;
            r_out_err   <= w_load_err;
         end else if (w_load_ok) begin
            r_out_nd    <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
         end
      end
   end
   assign out_data  = r_out_data;
   assign out_nd    = r_out_nd;
   assign out_first = r_out_first;
   assign out_last  = r_out_last;
   assign out_err   = r_out_err;
   assign count     = r_count;
   assign overflow  = r_overflow;
endmodule

// File: tb/tb_burst_stream_buffer.sv
// tb_burst_stream_buffer: scoreboard bench for burst_stream_buffer with a stream-mode vector table
module tb_burst_stream_buffer;
   localparam logic [31:0] ERR_CODE = 32'hDEADBEEF;
   logic        clk = 1'b0;
   logic        rst_n, in_nd, mode, flush, out_ready;
   logic [31:0] in_data, out_data;
   logic        out_nd, out_first, out_last, out_err, overflow;
   logic [6:0]  count;
   typedef struct packed {
      logic [31:0] d;
      logic        f;
      logic        l;
      logic        e;
   } exp_t;
   typedef struct {
      logic [31:0] d;
      int          gap;
      exp_t        exp;
   } vec_t;
   exp_t sb[$];
   exp_t e, held;
   vec_t vt[8];
   int   xfer_cyc[$];
   int   checks = 0, errors = 0, n_xfer = 0, cyc = 0, n0;
   logic stalled = 1'b0;
   bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   burst_stream_buffer dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .mode(mode),
      .flush(flush), .out_ready(out_ready), .out_data(out_data), .out_nd(out_nd),
      .out_first(out_first), .out_last(out_last), .out_err(out_err),
      .count(count), .overflow(overflow)
   );
   always #5 clk = ~clk;
   function automatic exp_t mk(input logic [31:0] d, input logic f, input logic l, input logic er);
      return {d, f, l, er};
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_empty(input string nm, input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick;
      chk(nm, 64'(sb.size()), 0);
      repeat (2) tick;
   endtask
   // transfers happen on the next posedge when out_nd && out_ready hold at the negedge
   always @(negedge clk) begin
      cyc++;
      if (rst_n && out_nd && out_ready) begin
         n_xfer++;
         xfer_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
         end else begin
            e = sb.pop_front();
            chk("xfer", 64'({out_data, out_first, out_last, out_err}), 64'(e));
         end
      end
      if (rst_n && stalled)
         chk("stall_hold", 64'({out_nd, out_data, out_first, out_last, out_err}), 64'({1'b1, held}));
      stalled = rst_n && out_nd && !out_ready;
      held    = {out_data, out_first, out_last, out_err};
   end
   initial begin
      vt[0] = '{32'h0000_0001, 0, mk(32'h0000_0001, 1, 1, 0)};
      vt[1] = '{32'h0000_0002, 0, mk(32'h0000_0002, 1, 1, 0)};
      vt[2] = '{32'h0000_0003, 2, mk(32'h0000_0003, 1, 1, 0)};
      vt[3] = '{32'hFFFF_FFFF, 1, mk(32'hFFFF_FFFF, 1, 1, 0)};
      vt[4] = '{32'h0000_0000, 0, mk(32'h0000_0000, 1, 1, 0)};
      vt[5] = '{32'hA5A5_A5A5, 3, mk(32'hA5A5_A5A5, 1, 1, 0)};
      vt[6] = '{32'h8000_0000, 0, mk(32'h8000_0000, 1, 1, 0)};
      vt[7] = '{32'h1234_5678, 1, mk(32'h1234_5678, 1, 1, 0)};
      rst_n = 1'b0; in_nd = 1'b0; in_data = '0; mode = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) tick;
      chk("reset_state", 64'({out_nd, out_first, out_last, out_err, out_data, count, overflow}), 0);
      rst_n = 1'b1;
      tick;
      // stream mode: back-to-back words leave on consecutive cycles
      xfer_cyc.delete();
      in_nd = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         sb.push_back(mk(32'(i), 1, 1, 0));
         in_data = 32'(i);
         tick;
      end
      in_nd = 1'b0;
      wait_empty("stream_drain", 10);
      chk("stream_nogap", 64'(xfer_cyc[2] - xfer_cyc[0]), 2);
      foreach (vt[i]) begin
         sb.push_back(vt[i].exp);
         in_data = vt[i].d;
         in_nd = 1'b1;
         tick;
         in_nd = 1'b0;
         repeat (vt[i].gap) tick;
      end
      wait_empty("table_drain", 20);
      // burst regrouping with irregular input gaps
      mode = 1'b1;
      tick;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) sb.push_back(mk(32'(i), i % 8 == 0, i % 8 == 7, 0));
         in_data = 32'(i);
         in_nd = 1'b1;
         tick;
         in_nd = 1'b0;
         if (i % 3 == 0) tick;
      end
      wait_empty("burst_drain", 40);
      chk("burst_residue", 64'(count), 4);
      // flush releases the 4 leftover words as a short burst
      for (int i = 16; i < 20; i++) sb.push_back(mk(32'(i), i == 16, i == 19, 0));
      flush = 1'b1;
      tick;
      flush = 1'b0;
      wait_empty("flush_drain", 20);
      chk("flush_count", 64'(count), 0);
      chk("flush_pending_clr", 64'(dut.r_flush_pending), 0);
      n0 = n_xfer;
      in_data = 32'd99;
      in_nd = 1'b1;
      tick;
      in_nd = 1'b0;
      repeat (5) tick;
      chk("no_stale_flush", 64'(n_xfer - n0), 0);
      chk("single_held", 64'(count), 1);
      sb.push_back(mk(32'd99, 1, 1, 0));
      flush = 1'b1;
      tick;
      flush = 1'b0;
      wait_empty("flush1_drain", 20);
      // back-pressure: out_ready toggles 1,0,0,1 through a full burst
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sb.push_back(mk(32'(100 + i), i == 0, i == 7, 0));
         in_data = 32'(100 + i);
         in_nd = 1'b1;
         tick;
      end
      in_nd = 1'b0;
      repeat (3) tick;
      for (int i = 0; i < 64 && sb.size() != 0; i++) begin
         out_ready = pat[i % 4];
         tick;
      end
      out_ready = 1'b1;
      wait_empty("bp_drain", 5);
      // overflow: 66 words into a stalled 64-deep FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         sb.push_back(mk(32'(i), i % 8 == 0, i % 8 == 7, 0));
         if (i == 7) sb.push_back(mk(ERR_CODE, 1, 1, 1));
      end
      in_nd = 1'b1;
      for (int i = 0; i < 66; i++) begin
         in_data = 32'(i);
         tick;
      end
      in_nd = 1'b0;
      chk("ovf_count", 64'(count), 64);
      chk("ovf_flag", 64'(overflow), 1);
      out_ready = 1'b1;
      wait_empty("ovf_drain", 200);
      chk("ovf_left", 64'(count), 1);
      chk("ovf_sticky", 64'(overflow), 1);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("reset_clears", 64'({out_nd, out_data, count, overflow}), 0);
      // reset while word 3 of a burst is held in the output register
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) sb.push_back(mk(32'(200 + i), i == 0, 0, 0));
      in_nd = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'(200 + i);
         tick;
      end
      in_nd = 1'b0;
      repeat (3) tick;
      out_ready = 1'b1;
      repeat (3) tick;
      out_ready = 1'b0;
      chk("midburst_word3", 64'({out_nd, out_data}), 64'({1'b1, 32'd203}));
      rst_n = 1'b0;
      tick;
      chk("midburst_reset", 64'({out_nd, out_first, out_last, out_err, out_data, count, overflow}), 0);
      chk("midburst_sb", 64'(sb.size()), 0);
      rst_n = 1'b1;
      // 200 words at full rate wrap the pointers several times
      mode = 1'b0;
      out_ready = 1'b1;
      tick;
      in_nd = 1'b1;
      for (int i = 0; i < 200; i++) begin
         sb.push_back(mk(32'(i * 7 + 3), 1, 1, 0));
         in_data = 32'(i * 7 + 3);
         tick;
      end
      in_nd = 1'b0;
      wait_empty("wrap_drain", 20);
      chk("wrap_overflow", 64'(overflow), 0);
      chk("wrap_count", 64'(count), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
